hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the MIPS pipeline. It replaces fixed per-stage decode with a registered scoreboard of in-flight register writes.
- Each record holds write-enable, destination register and a Tnew countdown. The record shifts through NSTAGE producer slots (E, M, W, ...) and its Tnew counter decrements every cycle.
- The block resolves D-stage rs/rt forwarding and stall from the youngest matching slot.
- It also owns the multiply/divide busy counter and its stall.

Parameters:
- AW, 5: register index width; register 0 is hardwired zero.
- DW, 32: data width.
- NSTAGE, 3: number of producer slots; slot 0 = E, slot 1 = M, slot 2 = W.
- TW, 3: Tnew/Tuse width.
- MUL_CYC, 5: busy cycles after a multiply start.
- DIV_CYC, 10: busy cycles after a divide start.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- d_rs  in  AW  D-stage rs index
- d_rt  in  AW  D-stage rt index
- d_tuse_rs  in  TW  cycles until rs is consumed
- d_tuse_rt  in  TW  cycles until rt is consumed
- d_we  in  1  D instruction writes the GRF
- d_a3  in  AW  D instruction destination register
- d_tnew  in  TW  Tnew of the D instruction when it enters E
- d_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- d_rdata1  in  DW  GRF read data for rs
- d_rdata2  in  DW  GRF read data for rt
- slot_data  in  NSTAGE*DW  result currently held by each slot; slot i occupies bits [i*DW +: DW]
- md_start  in  1  E stage issues a mult/div this cycle
- md_is_div  in  1  qualifies md_start as a divide
- flush  in  1  exception/eret flush
- fwd_rs  out  DW  forwarded rs value
- fwd_rt  out  DW  forwarded rt value
- rs_src  out  2  0 = GRF, 1+i = slot i (saturates at 3)
- rt_src  out  2  same encoding for rt
- stall  out  1  freeze F/D and insert a bubble into E
- md_busy  out  1  multiply/divide unit busy

Behaviour:
- Reset (asynchronous, active-low): all slot records invalid with Tnew = 0; md counter = 0.
  - Outputs after reset: stall = 0, md_busy = 0, fwd_* = d_rdata*, *_src = 0.
- Slot record = {valid, a3, tnew}. Each rising edge (not in reset):
  - Slot 0 loads {d_we && d_a3 != 0, d_a3, d_tnew} when stall = 0 and flush = 0; otherwise it loads a bubble.
  - Slot i (i ≥ 1) loads slot i-1, with tnew decremented and saturating at 0.
  - Slots always advance; stall only blocks insertion into slot 0.
- flush = 1: every slot becomes invalid at the next edge, the md counter clears to 0, and flush overrides all other inputs.
- Lookup, combinational, done independently for rs and rt:
  - If the index is 0: forward 0, src = 0, no stall.
  - Otherwise pick the lowest-numbered (youngest) valid slot whose a3 matches; older matches are ignored.
  - Match with tnew = 0: forward that slot's slot_data, src = slot + 1.
  - Match with tnew > tuse: raise stall; forwarded value = GRF data, src = 0.
  - Match with 0 < tnew ≤ tuse: no stall; forward GRF data. The later stage re-forwards.
  - No match: GRF data, src = 0. The GRF performs write-through for the retiring W write.
- md counter:
  - When md_start = 1 and the counter is 0: load DIV_CYC if md_is_div, else MUL_CYC.
  - A nonzero counter decrements by 1 per cycle.
  - md_start while the counter is nonzero is ignored; the counter does not reload.
  - md_busy = (counter != 0), registered.
- stall = stall_rs | stall_rt | (d_md && (md_start || md_busy)).
- Simultaneous md_start and flush: the flush wins and the counter stays 0.

Test Plan:
1. After reset release: stall = 0, md_busy = 0, fwd_rs = d_rdata1.
2. addu with d_a3 = 8, d_tnew = 1, followed by beq using rs = 8 with tuse = 0:
   - stall = 1 for exactly 1 cycle.
   - Next cycle fwd_rs = slot_data[1] (M) and rs_src = 2.
3. lw with d_a3 = 9, d_tnew = 2, followed by addu using rt = 9 with tuse = 1:
   - stall = 1 for 1 cycle.
   - Then no stall; the rt lookup returns GRF data with rt_src = 0 (Tnew ≤ Tuse).
4. Two writes to register 5 in slots 0 and 1, both with tnew = 0 and distinct slot_data → fwd_rs returns the slot 0 value (youngest wins).
5. md_start with md_is_div = 1, then an mflo in D:
   - md_busy is high for exactly 10 cycles and stall tracks it.
   - A second md_start during busy does not extend it.
6. Mid-divide flush or reset assertion → md_busy = 0 and all slots invalid on the next cycle. A dependent instruction then shows no stall, rs_src = 0, and reg-0 lookups return 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Registered scoreboard of in-flight GRF writes: resolves D-stage forwarding and
// stall from the youngest matching producer slot, and owns the mult/div busy counter.
module hazard_scoreboard #(
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 32,
    parameter int unsigned NSTAGE  = 3,
    parameter int unsigned TW      = 3,
    parameter int unsigned MUL_CYC = 5,
    parameter int unsigned DIV_CYC = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      d_rs,
    input  logic [AW-1:0]      d_rt,
    input  logic [TW-1:0]      d_tuse_rs,
    input  logic [TW-1:0]      d_tuse_rt,
    input  logic               d_we,
    input  logic [AW-1:0]      d_a3,
    input  logic [TW-1:0]      d_tnew,
    input  logic               d_md,
    input  logic [DW-1:0]      d_rdata1,
    input  logic [DW-1:0]      d_rdata2,
    input  logic [NSTAGE*DW-1:0] slot_data,
    input  logic               md_start,
    input  logic               md_is_div,
    input  logic               flush,
    output logic [DW-1:0]      fwd_rs,
    output logic [DW-1:0]      fwd_rt,
    output logic [1:0]         rs_src,
    output logic [1:0]         rt_src,
    output logic               stall,
    output logic               md_busy
);

    localparam int unsigned MD_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int unsigned CW     = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic [DW-1:0] fwd;
        logic [1:0]    src;
        logic          stall;
    } lookup_t;

    logic          valid_q [NSTAGE];
    logic          valid_d [NSTAGE];
    logic [AW-1:0] a3_q    [NSTAGE];
    logic [AW-1:0] a3_d    [NSTAGE];
    logic [TW-1:0] tnew_q  [NSTAGE];
    logic [TW-1:0] tnew_d  [NSTAGE];
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    lookup_t rs_lk, rt_lk;

    // Scan from slot 0 upward and keep only the first hit, so the youngest producer wins.
    function automatic lookup_t lookup(input logic [AW-1:0] idx,
                                       input logic [TW-1:0] tuse,
                                       input logic [DW-1:0] rdata);
        lookup_t       r;
        logic          found;
        logic [TW-1:0] t_sel;
        logic [DW-1:0] data_sel;
        logic [1:0]    src_sel;
        found    = 1'b0;
        t_sel    = '0;
        data_sel = '0;
        src_sel  = '0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            if (!found && valid_q[i] && a3_q[i] == idx) begin
                found    = 1'b1;
                t_sel    = tnew_q[i];
                data_sel = slot_data[i*DW +: DW];
                src_sel  = (i + 1 >= 3) ? 2'd3 : 2'(i + 1);
            end
        end
        r.fwd   = rdata;
        r.src   = '0;
        r.stall = 1'b0;
        if (idx == '0) begin
            r.fwd = '0;
        end else if (found) begin
            if (t_sel == '0) begin
                r.fwd = data_sel;
                r.src = src_sel;
            end else if (t_sel > tuse) begin
                r.stall = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        rs_lk   = lookup(d_rs, d_tuse_rs, d_rdata1);
        rt_lk   = lookup(d_rt, d_tuse_rt, d_rdata2);
        md_busy = (md_cnt_q != '0);
        stall   = rs_lk.stall | rt_lk.stall | (d_md && (md_start || md_busy));
        fwd_rs  = rs_lk.fwd;
        fwd_rt  = rt_lk.fwd;
        rs_src  = rs_lk.src;
        rt_src  = rt_lk.src;
    end

    always_comb begin
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            valid_d[i] = 1'b0;
            a3_d[i]    = '0;
            tnew_d[i]  = '0;
        end
        md_cnt_d = md_cnt_q;
        if (!flush) begin
            if (!stall) begin
                valid_d[0] = d_we && (d_a3 != '0);
                a3_d[0]    = d_a3;
                tnew_d[0]  = d_tnew;
            end
            for (int unsigned i = 1; i < NSTAGE; i++) begin
                valid_d[i] = valid_q[i-1];
                a3_d[i]    = a3_q[i-1];
                tnew_d[i]  = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - 1'b1;
            end
            if (md_cnt_q != '0) begin
                md_cnt_d = md_cnt_q - 1'b1;
            end else if (md_start) begin
                md_cnt_d = md_is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
            end
        end else begin
            md_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NSTAGE; i++) begin
                valid_q[i] <= 1'b0;
                a3_q[i]    <= '0;
                tnew_q[i]  <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NSTAGE; i++) begin
                valid_q[i] <= valid_d[i];
                a3_q[i]    <= a3_d[i];
                tnew_q[i]  <= tnew_d[i];
            end
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding priority, Tnew/Tuse stalls,
// mult/div busy window, flush and reset clearing.
module tb_hazard_scoreboard;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NS = 3;
    localparam int unsigned TW = 3;

    localparam logic [DW-1:0] S0 = 32'hAAAA_0000;
    localparam logic [DW-1:0] S1 = 32'hBBBB_1111;
    localparam logic [DW-1:0] S2 = 32'hCCCC_2222;
    localparam logic [DW-1:0] R1 = 32'h1111_1111;
    localparam logic [DW-1:0] R2 = 32'h2222_2222;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   d_rs, d_rt, d_a3;
    logic [TW-1:0]   d_tuse_rs, d_tuse_rt, d_tnew;
    logic            d_we, d_md, md_start, md_is_div, flush;
    logic [DW-1:0]   d_rdata1, d_rdata2;
    logic [NS*DW-1:0] slot_data;
    logic [DW-1:0]   fwd_rs, fwd_rt;
    logic [1:0]      rs_src, rt_src;
    logic            stall, md_busy;

    int total = 0;
    int bad   = 0;
    int busy_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .AW(AW), .DW(DW), .NSTAGE(NS), .TW(TW), .MUL_CYC(5), .DIV_CYC(10)
    ) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_we(d_we), .d_a3(d_a3), .d_tnew(d_tnew), .d_md(d_md),
        .d_rdata1(d_rdata1), .d_rdata2(d_rdata2), .slot_data(slot_data),
        .md_start(md_start), .md_is_div(md_is_div), .flush(flush),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .rs_src(rs_src), .rt_src(rt_src),
        .stall(stall), .md_busy(md_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_we = 1'b0; d_a3 = '0; d_tnew = '0; d_md = 1'b0;
        d_rs = '0; d_rt = '0; d_tuse_rs = '0; d_tuse_rt = '0;
        md_start = 1'b0; md_is_div = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        d_rdata1 = R1; d_rdata2 = R2;
        slot_data = {S2, S1, S0};
        d_rs = 5'd3; d_rt = 5'd4;
        #3;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_fwd_rs", fwd_rs, R1);
        check("rst_rs_src", 32'(rs_src), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(); #3;
        check("rel_stall", 32'(stall), 32'd0);
        check("rel_fwd_rs", fwd_rs, R1);
        check("rel_fwd_rt", fwd_rt, R2);

        // addu r8 (tnew 1) then beq on r8 (tuse 0)
        tick(); idle(); d_we = 1'b1; d_a3 = 5'd8; d_tnew = 3'd1; #3;
        check("addu_stall", 32'(stall), 32'd0);
        tick(); idle(); d_rs = 5'd8; d_tuse_rs = 3'd0; #3;
        check("beq_stall1", 32'(stall), 32'd1);
        check("beq_src_stall", 32'(rs_src), 32'd0);
        tick(); #3;
        check("beq_stall2", 32'(stall), 32'd0);
        check("beq_fwd", fwd_rs, S1);
        check("beq_src", 32'(rs_src), 32'd2);

        // lw r9 (tnew 2) then addu reading r9 as rt (tuse 1)
        tick(); idle(); tick(); tick(); tick();
        d_we = 1'b1; d_a3 = 5'd9; d_tnew = 3'd2;
        tick(); idle(); d_we = 1'b1; d_a3 = 5'd10; d_tnew = 3'd1; d_rt = 5'd9; d_tuse_rt = 3'd1; #3;
        check("lw_stall1", 32'(stall), 32'd1);
        tick(); #3;
        check("lw_stall2", 32'(stall), 32'd0);
        check("lw_fwd_rt", fwd_rt, R2);
        check("lw_rt_src", 32'(rt_src), 32'd0);

        // two writes to r5 with tnew 0: youngest wins, then it ages through the slots
        tick(); idle(); tick(); tick(); tick();
        d_we = 1'b1; d_a3 = 5'd5; d_tnew = 3'd0;
        tick(); tick(); idle(); d_rs = 5'd5; #3;
        check("young_fwd", fwd_rs, S0);
        check("young_src", 32'(rs_src), 32'd1);
        check("young_stall", 32'(stall), 32'd0);
        tick(); #3;
        check("age1_fwd", fwd_rs, S1);
        check("age1_src", 32'(rs_src), 32'd2);
        tick(); #3;
        check("age2_fwd", fwd_rs, S2);
        check("age2_src", 32'(rs_src), 32'd3);
        tick(); #3;
        check("age3_fwd", fwd_rs, R1);
        check("age3_src", 32'(rs_src), 32'd0);

        // divide with mflo waiting in D; a second start mid-busy must be ignored
        tick(); idle(); md_start = 1'b1; md_is_div = 1'b1; d_md = 1'b1; #3;
        check("md_start_stall", 32'(stall), 32'd1);
        check("md_start_busy", 32'(md_busy), 32'd0);
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            md_start = (k == 3);
            md_is_div = 1'b0;
            #3;
            if (md_busy) busy_cycles++;
            check("md_stall_track", 32'(stall), 32'(md_busy | md_start));
        end
        check("md_busy_len", 32'(busy_cycles), 32'd10);
        check("md_end_busy", 32'(md_busy), 32'd0);

        // flush mid-divide with a pending slow write to r6
        tick(); idle(); md_start = 1'b1; md_is_div = 1'b1; d_we = 1'b1; d_a3 = 5'd6; d_tnew = 3'd3;
        tick(); idle(); d_rs = 5'd6; #3;
        check("pre_flush_busy", 32'(md_busy), 32'd1);
        check("pre_flush_stall", 32'(stall), 32'd1);
        tick(); flush = 1'b1; md_start = 1'b1; md_is_div = 1'b1; d_we = 1'b1; d_a3 = 5'd6; d_tnew = 3'd3;
        tick(); idle(); d_rs = 5'd6; #3;
        check("flush_busy", 32'(md_busy), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_rs_src", 32'(rs_src), 32'd0);
        check("flush_fwd_rs", fwd_rs, R1);
        d_rs = 5'd0; d_rt = 5'd0; #1;
        check("r0_fwd_rs", fwd_rs, 32'd0);
        check("r0_fwd_rt", fwd_rt, 32'd0);

        // asynchronous reset mid-divide
        tick(); idle(); md_start = 1'b1; md_is_div = 1'b1;
        tick(); idle(); #3;
        check("pre_rst_busy", 32'(md_busy), 32'd1);
        reset = 1'b0; #1;
        check("async_rst_busy", 32'(md_busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(); #3;
        check("post_rst_busy", 32'(md_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
